// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared word width, length-clamp width and controller state encoding
package wide_add_pkg;
  localparam int WORD_W = 32;
  localparam int LEN_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/csla_bec32.sv
// csla_bec32: 32-bit carry-select adder, 8-bit blocks using a +1 (binary-to-excess-1) path; ports a, b, cin -> sum, cout
module csla_bec32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [8:0] r0, r1;
    assign r0 = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]};
    assign r1 = r0 + 9'd1;
    assign {c[g+1], sum[g*8 +: 8]} = c[g] ? r1 : r0;
  end
  assign cout = c[4];
endmodule

// File: rtl/wide_add_ctrl.sv
// wide_add_ctrl: multi-word adder reusing one 32-bit adder, LSW first, one word per clock; in_valid/in_ready request (in_a, in_b, in_cin, in_len[, in_sub]) -> out_valid/out_ready result (out_sum, out_cout); WIDE_ADD_SUB_EN adds in_sub for A-B
module wide_add_ctrl
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORDS*WORD_W-1:0] in_a,
  input  logic [NWORDS*WORD_W-1:0] in_b,
  input  logic                     in_cin,
  input  logic [LEN_W-1:0]         in_len,
`ifdef WIDE_ADD_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NWORDS*WORD_W-1:0] out_sum,
  output logic                     out_cout
);
  localparam int W = NWORDS * WORD_W;
  state_t state, state_n;
  logic [W-1:0] a_q, b_q, sum_q;
  logic carry_q, cout_q, co, last;
  logic [LEN_W-1:0] idx, len_q, eff_len;
  logic [WORD_W-1:0] s;
  assign eff_len = (in_len == '0 || in_len > LEN_W'(NWORDS)) ? LEN_W'(NWORDS) : in_len;
  assign last = (idx == len_q - 1'b1);
  csla_bec32 u_add (
    .a    (a_q[idx*WORD_W +: WORD_W]),
    .b    (b_q[idx*WORD_W +: WORD_W]),
    .cin  (carry_q),
    .sum  (s),
    .cout (co)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      idx <= '0;
      len_q <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q <= in_a;
      len_q <= eff_len;
      sum_q <= '0;
      cout_q <= 1'b0;
      idx <= '0;
`ifdef WIDE_ADD_SUB_EN
      b_q <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub | in_cin;
`else
      b_q <= in_b;
      carry_q <= in_cin;
`endif
    end else if (state == RUN) begin
      sum_q[idx*WORD_W +: WORD_W] <= s;
      carry_q <= co;
      idx <= idx + 1'b1;
      if (last) cout_q <= co;
    end
  end
  assign out_sum = sum_q;
  assign out_cout = cout_q;
endmodule

// File: tb/tb_wide_add_ctrl.sv
// tb_wide_add_ctrl: directed and random scoreboard checks of wide_add_ctrl with NWORDS=4
module tb_wide_add_ctrl;
  localparam int NW = 4;
  localparam int W = NW * 32;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [W-1:0] in_a, in_b, out_sum;
  logic [3:0] in_len;
`ifdef WIDE_ADD_SUB_EN
  logic in_sub;
`endif
  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  string cur = "init";
  logic [W-1:0] snap;
  always #5 clk = ~clk;
  wide_add_ctrl #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_len    (in_len),
`ifdef WIDE_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );
  `define CHK(name, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s/%s observed=%0h expected=%0h", cur, name, (obs), (exp)); end end
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic [3:0] len, input logic sub);
    int n = (len == 0 || len > NW) ? NW : int'(len);
    logic [W:0] mask = ((W+1)'(1) << (n * 32)) - (W+1)'(1);
    logic [W-1:0] bb = sub ? ~b : b;
    logic c = sub ? 1'b1 : cin;
    logic [W:0] r;
    exp_t e;
    r = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + {{W{1'b0}}, c};
    e.sum = r[W-1:0] & mask[W-1:0];
    e.cout = r[n*32];
    e.lat = n;
    return e;
  endfunction
  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic [3:0] len, input logic sub);
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_len = len;
`ifdef WIDE_ADD_SUB_EN
    in_sub = sub;
`endif
    in_valid = 1'b1;
    `CHK("ready", in_ready, 1'b1)
    sb.push_back(model(a, b, cin, len, sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    `CHK("busy", in_ready, 1'b0)
  endtask
  task automatic wait_done();
    int cyc = 0;
    exp_t e;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    `CHK("valid", out_valid, 1'b1)
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s/scoreboard empty", cur);
    end else begin
      e = sb.pop_front();
      `CHK("latency", cyc, e.lat)
      `CHK("sum", out_sum, e.sum)
      `CHK("cout", out_cout, e.cout)
    end
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    `CHK("idle_ready", in_ready, 1'b1)
    `CHK("idle_valid", out_valid, 1'b0)
  endtask
  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic [3:0] len, input logic sub);
    send(a, b, cin, len, sub);
    wait_done();
    release_out();
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    in_len = '0;
`ifdef WIDE_ADD_SUB_EN
    in_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cur = "reset";
    `CHK("in_ready", in_ready, 1'b1)
    `CHK("out_valid", out_valid, 1'b0)
    `CHK("out_sum", out_sum, {W{1'b0}})
    `CHK("out_cout", out_cout, 1'b0)
    cur = "carry_chain";
    send(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 4'd4, 1'b0);
    wait_done();
    `CHK("lit_sum", out_sum, 128'h00000001_00000000_00000000_00000000)
    `CHK("lit_cout", out_cout, 1'b0)
    release_out();
    cur = "len2";
    send({W{1'b1}}, {W{1'b1}}, 1'b1, 4'd2, 1'b0);
    wait_done();
    `CHK("lit_sum", out_sum, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF)
    `CHK("lit_cout", out_cout, 1'b1)
    release_out();
    cur = "len0";
    txn(rnd(), rnd(), 1'b1, 4'd0, 1'b0);
    cur = "len9";
    txn(rnd(), rnd(), 1'b0, 4'd9, 1'b0);
    cur = "len15";
    txn({W{1'b1}}, 128'd1, 1'b0, 4'd15, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cur = $sformatf("rand%0d", i);
      txn(rnd(), rnd(), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 4)), 1'b0);
    end
    cur = "stall";
    send(rnd(), rnd(), 1'b1, 4'd3, 1'b0);
    wait_done();
    snap = out_sum;
    in_valid = 1'b1;
    in_a = {W{1'b1}};
    in_b = {W{1'b1}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      `CHK("stable_sum", out_sum, snap)
      `CHK("stall_ready", in_ready, 1'b0)
      `CHK("stall_valid", out_valid, 1'b1)
    end
    in_valid = 1'b0;
    release_out();
    cur = "abort";
    send(rnd(), rnd(), 1'b1, 4'd4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    void'(sb.pop_back());
    `CHK("rst_ready", in_ready, 1'b1)
    `CHK("rst_valid", out_valid, 1'b0)
    `CHK("rst_sum", out_sum, {W{1'b0}})
    `CHK("rst_cout", out_cout, 1'b0)
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      `CHK("no_result", out_valid, 1'b0)
    end
    cur = "after_abort";
    txn(rnd(), rnd(), 1'b0, 4'd4, 1'b0);
`ifdef WIDE_ADD_SUB_EN
    cur = "sub_borrow";
    send(128'd5, 128'd7, 1'b0, 4'd1, 1'b1);
    wait_done();
    `CHK("lit_sum", out_sum, 128'hFFFFFFFE)
    `CHK("lit_cout", out_cout, 1'b0)
    release_out();
    cur = "sub_noborrow";
    send(128'd7, 128'd5, 1'b0, 4'd1, 1'b1);
    wait_done();
    `CHK("lit_sum", out_sum, 128'd2)
    `CHK("lit_cout", out_cout, 1'b1)
    release_out();
    cur = "sub_rand";
    txn(rnd(), rnd(), 1'b0, 4'd4, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
